fetch_queue: RTL and testbench

- Instruction-fetch front end directly upstream of the pipelined datapath/control pair; supplies the 32-bit instruction word and its PC to decode.
- Generates sequential PCs and issues in-order requests to instruction memory. Buffers returned words in a small FIFO with credit-based flow control.
- Accepts branch redirects from the execute stage: flushes buffered words and discards stale in-flight responses.

---
 rtl/fetch_pkg.sv | 14 +
 rtl/fetch_fifo.sv | 74 +++++++
 rtl/fetch_queue.sv | 118 +++++++++++
 tb/tb_fetch_queue.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared fetch-stage types and constants.
// Exports ADDR_W, INSTR_W, PC_STEP and the fetch_entry_t FIFO payload.
package fetch_pkg;

    localparam int ADDR_W  = 64;
    localparam int INSTR_W = 32;
    localparam int PC_STEP = 4;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Registered FIFO of fetch entries with a synchronous clear.
// Ports: push/push_data write, pop read, clear flush, full/empty/count status, head = oldest entry.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push,
    input  fetch_entry_t           push_data,
    input  logic                   pop,
    input  logic                   clear,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] count,
    output fetch_entry_t           head
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          do_pop;
    fetch_entry_t  mem_q [DEPTH];

    // Popping an empty FIFO is a no-op.
    assign do_pop = pop && (count_q != '0);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clear) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            if (push && !clear) begin
                mem_q[wr_ptr_q] <= push_data;
            end
        end
    end

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;
    assign head  = mem_q[rd_ptr_q];

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch front end: sequential PC generation, credit-limited imem requests,
// response buffering, and redirect flush with stale-response dropping.
// Ports: clk/reset; imem_req_* request, imem_resp_* response; redirect_*; deq_* to decode.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int                ADDR_W   = fetch_pkg::ADDR_W,
    parameter int                INSTR_W  = fetch_pkg::INSTR_W,
    parameter int                DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req_valid,
    output logic [ADDR_W-1:0]  imem_req_addr,
    input  logic               imem_req_ready,
    input  logic               imem_resp_valid,
    input  logic [INSTR_W-1:0] imem_resp_data,
    input  logic               redirect_valid,
    input  logic [ADDR_W-1:0]  redirect_pc,
    output logic               deq_valid,
    output logic [INSTR_W-1:0] deq_instr,
    output logic [ADDR_W-1:0]  deq_pc,
    input  logic               deq_ready
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] resp_pc_q, resp_pc_d;
    logic [CW-1:0]     outstanding_q, outstanding_d;
    logic [CW-1:0]     drop_cnt_q, drop_cnt_d;
    logic [CW-1:0]     fifo_count;
    logic [CW:0]       in_use;
    logic              fifo_full, fifo_empty;
    logic              credit_ok, req_fire, resp_ok;
    logic              push, pop;
    fetch_entry_t      push_data, head;

    // Buffered plus in-flight words may never exceed DEPTH, so a push always fits.
    assign in_use    = {1'b0, fifo_count} + {1'b0, outstanding_q};
    assign credit_ok = in_use < (CW+1)'(DEPTH);

    assign imem_req_valid = !reset && !redirect_valid && credit_ok;
    assign imem_req_addr  = fetch_pc_q;
    assign req_fire       = imem_req_valid && imem_req_ready;

    // Responses to requests issued before a reset are not tracked.
    assign resp_ok   = imem_resp_valid && (outstanding_q != '0);
    assign push      = resp_ok && !redirect_valid && (drop_cnt_q == '0);
    assign push_data = {imem_resp_data, resp_pc_q};

    assign deq_valid = !fifo_empty && !redirect_valid;
    assign pop       = deq_valid && deq_ready;
    assign deq_instr = head.instr;
    assign deq_pc    = head.pc;

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        resp_pc_d     = resp_pc_q;
        drop_cnt_d    = drop_cnt_q;
        outstanding_d = outstanding_q + CW'(req_fire) - CW'(resp_ok);
        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            resp_pc_d  = redirect_pc;
            // Everything still in flight is stale; a response landing now is dropped here.
            drop_cnt_d = outstanding_q - CW'(resp_ok);
        end else begin
            if (req_fire) begin
                fetch_pc_d = fetch_pc_q + ADDR_W'(PC_STEP);
            end
            if (resp_ok) begin
                if (drop_cnt_q != '0) begin
                    drop_cnt_d = drop_cnt_q - CW'(1);
                end else begin
                    resp_pc_d = resp_pc_q + ADDR_W'(PC_STEP);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_pc_q    <= RESET_PC;
            resp_pc_q     <= RESET_PC;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            resp_pc_q     <= resp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .clear     (redirect_valid),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count),
        .head      (head)
    );

    a_no_push_full: assert property (@(posedge clk) disable iff (reset)
        !(push && fifo_full));
    a_out_bound: assert property (@(posedge clk) disable iff (reset)
        outstanding_q <= CW'(DEPTH));
    a_drop_bound: assert property (@(posedge clk) disable iff (reset)
        drop_cnt_q <= outstanding_q);

endmodule

// File: tb/tb_fetch_queue.sv
// Directed scoreboard bench for fetch_queue.
// Models an in-order instruction memory with programmable latency.
module tb_fetch_queue;

    localparam int AW = 64;
    localparam int IW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          imem_req_valid;
    logic [AW-1:0] imem_req_addr;
    logic          imem_req_ready;
    logic          imem_resp_valid;
    logic [IW-1:0] imem_resp_data;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          deq_valid;
    logic [IW-1:0] deq_instr;
    logic [AW-1:0] deq_pc;
    logic          deq_ready;

    typedef struct {
        int            due;
        logic [IW-1:0] data;
    } mem_rsp_t;

    typedef struct {
        logic [AW-1:0] pc;
        logic [IW-1:0] instr;
    } exp_t;

    mem_rsp_t      mem_q [$];
    exp_t          sb_q [$];
    int            vectors = 0;
    int            errors  = 0;
    int            cyc     = 0;
    int            lat     = 1;
    int            n_req, n_deq;
    int            first_req_cyc, first_deq_cyc;
    bit            got_first;
    logic [AW-1:0] exp_pc;
    logic [AW-1:0] first_pc;

    fetch_queue dut (
        .clk             (clk),
        .reset           (reset),
        .imem_req_valid  (imem_req_valid),
        .imem_req_addr   (imem_req_addr),
        .imem_req_ready  (imem_req_ready),
        .imem_resp_valid (imem_resp_valid),
        .imem_resp_data  (imem_resp_data),
        .redirect_valid  (redirect_valid),
        .redirect_pc     (redirect_pc),
        .deq_valid       (deq_valid),
        .deq_instr       (deq_instr),
        .deq_pc          (deq_pc),
        .deq_ready       (deq_ready)
    );

    always #5 clk = ~clk;

    function automatic logic [IW-1:0] word_of(input logic [AW-1:0] a);
        return a[31:0] ^ 32'hDEAD_BEEF ^ {a[7:0], 24'h0};
    endfunction

    task automatic check(input string tag, input logic [AW-1:0] obs,
                         input logic [AW-1:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive the memory response, sample at negedge+1, update the model.
    task automatic cycle();
        mem_rsp_t m;
        exp_t     e;
        if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
            m = mem_q.pop_front();
            imem_resp_valid = 1'b1;
            imem_resp_data  = m.data;
        end else begin
            imem_resp_valid = 1'b0;
            imem_resp_data  = '0;
        end
        #1;
        if (redirect_valid) begin
            check("redir_no_req", AW'(imem_req_valid), '0);
            check("redir_no_deq", AW'(deq_valid), '0);
        end
        if (imem_req_valid && imem_req_ready) begin
            check("req_addr", imem_req_addr, exp_pc);
            m.due  = cyc + lat;
            m.data = word_of(imem_req_addr);
            mem_q.push_back(m);
            e.pc    = exp_pc;
            e.instr = word_of(exp_pc);
            sb_q.push_back(e);
            exp_pc += 64'd4;
            if (n_req == 0) first_req_cyc = cyc;
            n_req++;
        end
        if (deq_valid && first_deq_cyc < 0) first_deq_cyc = cyc;
        if (deq_valid && deq_ready) begin
            n_deq++;
            if (!got_first) begin
                first_pc  = deq_pc;
                got_first = 1'b1;
            end
            check("deq_expected", AW'(sb_q.size() != 0), AW'(1));
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                check("deq_pc", deq_pc, e.pc);
                check("deq_instr", AW'(deq_instr), AW'(e.instr));
            end
        end
        if (redirect_valid) begin
            sb_q.delete();
            exp_pc = redirect_pc;
        end
        @(posedge clk);
        @(negedge clk);
        cyc++;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic redirect(input logic [AW-1:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        cycle();
        redirect_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset           = 1'b1;
        redirect_valid  = 1'b0;
        redirect_pc     = '0;
        deq_ready       = 1'b0;
        imem_req_ready  = 1'b1;
        imem_resp_valid = 1'b0;
        imem_resp_data  = '0;
        mem_q.delete();
        sb_q.delete();
        exp_pc        = '0;
        n_req         = 0;
        n_deq         = 0;
        first_req_cyc = -1;
        first_deq_cyc = -1;
        got_first     = 1'b0;
        first_pc      = 'x;
        repeat (2) @(negedge clk);
        #1;
        check("rst_req_valid", AW'(imem_req_valid), '0);
        check("rst_deq_valid", AW'(deq_valid), '0);
        check("rst_deq_instr", AW'(deq_instr), '0);
        check("rst_deq_pc", deq_pc, '0);
        reset = 1'b0;
    endtask

    initial begin
        // Sequential fetch, latency 1, always consuming.
        do_reset();
        lat       = 1;
        deq_ready = 1'b1;
        run(12);
        check("t1_latency", AW'(first_deq_cyc - first_req_cyc), 64'd2);
        check("t1_deq_count", AW'(n_deq), 64'd10);
        check("t1_first_pc", first_pc, 64'h0);

        // Stalled decode: credits stop issue at DEPTH, then drain and resume.
        do_reset();
        lat       = 1;
        deq_ready = 1'b0;
        run(10);
        check("t2_req_count", AW'(n_req), 64'd4);
        check("t2_req_blocked", AW'(imem_req_valid), '0);
        deq_ready = 1'b1;
        run(10);
        check("t2_deq_count", AW'(n_deq), 64'd10);
        check("t2_req_total", AW'(n_req), 64'd13);

        // Latency 3, three requests in flight, redirect drops all of them.
        do_reset();
        lat       = 3;
        deq_ready = 1'b1;
        redirect(64'h20);
        run(3);
        check("t3_inflight", AW'(n_req), 64'd3);
        check("t3_no_deq", AW'(n_deq), '0);
        got_first = 1'b0;
        redirect(64'h100);
        run(12);
        check("t3_first_pc", first_pc, 64'h100);

        // Redirect coinciding with a response and a ready pop.
        do_reset();
        lat       = 1;
        deq_ready = 1'b1;
        run(6);
        check("t4_streaming", AW'(deq_valid), AW'(1));
        got_first = 1'b0;
        redirect(64'h100);
        run(6);
        check("t4_first_pc", first_pc, 64'h100);

        // Back-to-back redirects: only the later target is delivered.
        do_reset();
        lat       = 3;
        deq_ready = 1'b1;
        redirect(64'h200);
        run(1);
        redirect(64'h300);
        run(12);
        check("t5_first_pc", first_pc, 64'h300);

        // Asynchronous reset with two entries buffered.
        do_reset();
        lat       = 1;
        deq_ready = 1'b0;
        run(3);
        check("t6_buffered", AW'(deq_valid), AW'(1));
        reset = 1'b1;
        #1;
        check("t6_async_deq", AW'(deq_valid), '0);
        check("t6_async_req", AW'(imem_req_valid), '0);
        check("t6_async_pc", deq_pc, '0);
        do_reset();
        lat       = 1;
        deq_ready = 1'b1;
        run(8);
        check("t6_restart_pc", first_pc, 64'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
